mem_access_seq: RTL

Memory-access sequencer between the microprogrammed control unit and data memory. It accepts one load/store request from a control-unit state and runs the MOV/MFC handshake with memory. It aligns byte/halfword data and returns a one-cycle completion pulse, which the control unit uses as its mfc condition input. Misaligned accesses are rejected without touching memory.

---
 rtl/mem_access_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// Load/store sequencer running the MOV/MFC handshake to data memory, with byte/halfword lane alignment.
// Optional WAIT watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_seq #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mov,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mfc,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, mov_q, mov_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic              mem_rw_q, mem_rw_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              misalign, tmo;
  logic [DATA_W-1:0] load_val, rep_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter idles at zero outside WAIT, so it is already cleared on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT && !mfc) cnt_d = cnt_q + 1'b1;
  end
  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = (TIMEOUT < 0);
`endif

  always_comb begin
    misalign = (size == 2'b11) ||
               (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
    case (size)
      2'b00:   rep_wdata = {4{wdata[7:0]}};
      2'b01:   rep_wdata = {2{wdata[15:0]}};
      default: rep_wdata = wdata;
    endcase
  end

  always_comb begin
    load_val = mem_rdata;
    case (mem_size_q)
      2'b00: begin
        case (mem_addr_q[1:0])
          2'b00:   load_val = {24'b0, mem_rdata[7:0]};
          2'b01:   load_val = {24'b0, mem_rdata[15:8]};
          2'b10:   load_val = {24'b0, mem_rdata[23:16]};
          default: load_val = {24'b0, mem_rdata[31:24]};
        endcase
      end
      2'b01:   load_val = mem_addr_q[1] ? {16'b0, mem_rdata[31:16]} : {16'b0, mem_rdata[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_rw_d    = mem_rw_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: if (req) begin
        mem_rw_d    = rw;
        mem_size_d  = size;
        mem_addr_d  = addr;
        mem_wdata_d = rep_wdata;
        err_d       = misalign;
        if (misalign) begin
          state_d = DONE;
          rdata_d = '0;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // mfc on the timeout edge still completes normally
        if (mfc) begin
          state_d = DONE;
          rdata_d = mem_rw_q ? '0 : load_val;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    mov_d  = (state_d == ISSUE) || (state_d == WAIT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mov_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_rw_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mov_q       <= mov_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_rw_q    <= mem_rw_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mov       = mov_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_rw    = mem_rw_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
